avalon_mem_responder: RTL and testbench

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

---
 rtl/avalon_mem_responder_pkg.sv | 8 +
 rtl/avalon_mem_responder_latency_pipe.sv | 27 ++
 rtl/avalon_mem_responder.sv | 69 ++++++
 tb/tb_avalon_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mem_responder_pkg.sv
// avalon_mem_responder_pkg: shared state enum, out-of-range read pattern and parameter defaults
package avalon_mem_responder_pkg;
  typedef enum logic {IDLE, STALL} state_t;
  localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_WAIT_CYCLES = 1;
  localparam int DEF_READ_LATENCY = 2;
endpackage

// File: rtl/avalon_mem_responder_latency_pipe.sv
// memresp_latency_pipe: fixed-latency valid/data shift register with synchronous flush
module memresp_latency_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0][WIDTH-1:0] d;
  logic [LATENCY:0] nv;
  logic [LATENCY:0][WIDTH-1:0] nd;
  assign nv = {v, in_valid};
  assign nd = {d, in_data};
  assign out_valid = nv[LATENCY];
  assign out_data = nd[LATENCY];
  // data only moves with a valid token so the last stage holds the previous return
  always_ff @(posedge clk)
    for (int i = 0; i < LATENCY; i++) begin
      v[i] <= flush ? 1'b0 : nv[i];
      d[i] <= flush ? '0 : nv[i] ? nd[i] : d[i];
    end
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM memory slave with stall insertion and pipelined fixed-latency reads
// Define AVALON_MEM_RESPONDER_STATS_EN to add rd_count/wr_count accepted-command counters.
module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid
`ifdef AVALON_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state;
  logic [3:0] cnt;
  logic cmd, accept, rd_accept, wr_accept, in_range, unused_addr;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign cmd = slave_read | slave_write;
  assign slave_waitrequest = rst_n && cmd && (state == IDLE ? WC != 4'd0 : cnt != WC);
  assign accept = rst_n && cmd && !slave_waitrequest;
  assign wr_accept = accept && slave_write;
  assign rd_accept = accept && !slave_write;
  assign idx = slave_address[AW+1:2];
  assign in_range = slave_address[31:AW+2] == '0;
  assign unused_addr = ^slave_address[1:0];
  // cnt counts cycles already stalled; withdrawal or acceptance both return to IDLE
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= cmd && slave_waitrequest ? STALL : IDLE;
      cnt <= cmd && slave_waitrequest ? cnt + 4'd1 : 4'd0;
    end
  always_ff @(posedge clk)
    if (wr_accept && in_range) mem[idx] <= slave_writedata;
  memresp_latency_pipe #(.LATENCY(READ_LATENCY), .WIDTH(32)) u_pipe (
    .clk(clk),
    .flush(!rst_n),
    .in_valid(rd_accept),
    .in_data(in_range ? mem[idx] : OOR_DATA),
    .out_valid(slave_readdatavalid),
    .out_data(slave_readdata)
  );
`ifdef AVALON_MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= rd_count + 32'(rd_accept);
      wr_count <= wr_count + 32'(wr_accept);
    end
`endif
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: two configurations (stall=1/lat=2, stall=0/lat=3) checked against a queue-based model
module tb_avalon_mem_responder;
  logic clk = 0, rst_n = 0;
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic rd [2], wr [2], wreq [2], rdv [2];
`ifdef AVALON_MEM_RESPONDER_STATS_EN
  logic [31:0] rc [2], wc [2];
`endif
  int errors = 0, checks = 0;
  int vcnt [2] = '{0, 0};
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int W = k == 0 ? 1 : 0;
    localparam int L = k == 0 ? 2 : 3;
    typedef struct { int due; logic [31:0] d; bit kn; } ent_t;
    ent_t q [$];
    ent_t e;
    logic [31:0] mm [256];
    bit kn [256];
    logic [31:0] last = 0, rcnt = 0, wcnt = 0;
    logic [7:0] idx;
    bit last_kn = 0, acc, inr, cmd, ev;
    int hold = 0, cyc = 0;
    avalon_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W), .READ_LATENCY(L)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .slave_address(addr[k]),
      .slave_read(rd[k]),
      .slave_write(wr[k]),
      .slave_writedata(wdata[k]),
      .slave_waitrequest(wreq[k]),
      .slave_readdata(rdata[k]),
      .slave_readdatavalid(rdv[k])
`ifdef AVALON_MEM_RESPONDER_STATS_EN
      ,
      .rd_count(rc[k]),
      .wr_count(wc[k])
`endif
    );
    // model: a command is taken on the (W+1)th consecutive cycle it is held
    always @(posedge clk) begin
      cmd = rd[k] | wr[k];
      if (!rst_n) begin
        hold = 0;
        q.delete();
        last = 0;
        last_kn = 1;
        rcnt = 0;
        wcnt = 0;
      end else begin
        acc = cmd && hold == W;
        inr = addr[k] < 32'd1024;
        idx = addr[k][9:2];
        if (acc && wr[k]) begin
          if (inr) begin
            mm[idx] = wdata[k];
            kn[idx] = 1;
          end
          wcnt++;
        end else if (acc) begin
          e.due = cyc + L;
          e.d = inr ? mm[idx] : 32'hDEADBEEF;
          e.kn = inr ? kn[idx] : 1'b1;
          q.push_back(e);
          rcnt++;
        end
        hold = cmd && !acc ? hold + 1 : 0;
      end
      cyc++;
    end
    always @(negedge clk) begin
      chk($sformatf("waitrequest%0d", k), 32'(wreq[k]), 32'(rst_n && (rd[k] | wr[k]) && hold < W));
      ev = q.size() > 0 && q[0].due == cyc;
      chk($sformatf("readdatavalid%0d", k), 32'(rdv[k]), 32'(ev));
      if (rdv[k]) vcnt[k]++;
      if (ev) begin
        if (q[0].kn) chk($sformatf("readdata%0d", k), rdata[k], q[0].d);
        last = q[0].d;
        last_kn = q[0].kn;
        q.pop_front();
      end else if (last_kn) chk($sformatf("readdata_hold%0d", k), rdata[k], last);
`ifdef AVALON_MEM_RESPONDER_STATS_EN
      chk($sformatf("rd_count%0d", k), rc[k], rcnt);
      chk($sformatf("wr_count%0d", k), wc[k], wcnt);
`endif
    end
  end

  task automatic issue(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, output int st);
    bit w0, ok;
    rd[k] = r;
    wr[k] = w;
    addr[k] = a;
    wdata[k] = d;
    st = 0;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      w0 = wreq[k];
      @(posedge clk);
      #1;
      if (!w0) ok = 1;
      else st++;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int k, input int n);
    rd[k] = 0;
    wr[k] = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int k, output int lat, output logic [31:0] d);
    lat = 0;
    d = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (rdv[k]) begin
        lat = n;
        d = rdata[k];
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic rnd(input int k, input int n);
    int st;
    bit r, w;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: begin r = 0; w = 1; end
        7: begin r = 1; w = 1; end
        default: begin r = 1; w = 0; end
      endcase
      a = $urandom_range(0, 7) == 0 ? 32'd1024 + 32'($urandom_range(0, 4096))
                                     : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        rd[k] = r;
        wr[k] = w;
        addr[k] = a;
        wdata[k] = $urandom;
        @(posedge clk);
        #1;
        rd[k] = 0;
        wr[k] = 0;
      end else issue(k, r, w, a, $urandom, st);
      if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
    end
    idle(k, 8);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st, lat, v0, got, first, lastc;
    logic [31:0] d;
    logic [31:0] seen [3];
    for (int k = 0; k < 2; k++) begin
      rd[k] = 0;
      wr[k] = 0;
      addr[k] = 0;
      wdata[k] = 0;
    end
    @(negedge clk);
    chk("wreq_in_reset", 32'(wreq[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("reset_rdv", 32'(rdv[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_wreq", 32'(wreq[0]), 32'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 1, 32'd0, 32'h11, st);
    chk("wr_stall", st, 1);
    issue(0, 1, 0, 32'd0, 32'd0, st);
    chk("rd_stall", st, 1);
    idle(0, 0);
    wait_valid(0, lat, d);
    chk("rd_latency", lat, 2);
    chk("rd_data", d, 32'h11);
    issue(0, 1, 0, 32'd1024, 32'd0, st);
    idle(0, 0);
    wait_valid(0, lat, d);
    chk("oor_read", d, 32'hDEADBEEF);
    issue(0, 0, 1, 32'd1024, 32'h5, st);
    issue(0, 1, 0, 32'd0, 32'd0, st);
    idle(0, 0);
    wait_valid(0, lat, d);
    chk("oor_write_ignored", d, 32'h11);
    v0 = vcnt[0];
    rd[0] = 1;
    addr[0] = 0;
    @(negedge clk);
    chk("stall_wreq", 32'(wreq[0]), 32'd1);
    @(posedge clk);
    #1;
    rd[0] = 0;
    @(negedge clk);
    chk("withdraw_wreq", 32'(wreq[0]), 32'd0);
    @(posedge clk);
    #1;
    idle(0, 5);
    chk("withdraw_no_valid", vcnt[0], v0);
    issue(0, 1, 0, 32'd0, 32'd0, st);
    chk("reissue_stall", st, 1);
    idle(0, 0);
    wait_valid(0, lat, d);
    chk("reissue_data", d, 32'h11);
    issue(0, 0, 1, 32'd8, 32'hABCD, st);
    issue(0, 1, 0, 32'd8, 32'd0, st);
    idle(0, 0);
    v0 = vcnt[0];
    pulse_reset();
    idle(0, 6);
    chk("flush_no_valid", vcnt[0], v0);
    issue(0, 1, 0, 32'd8, 32'd0, st);
    idle(0, 0);
    wait_valid(0, lat, d);
    chk("mem_kept", d, 32'hABCD);
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 1, 32'(4 * i), 32'(i + 1), st);
      chk("nowait_stall", st, 0);
    end
    for (int i = 0; i < 3; i++) issue(1, 1, 0, 32'(4 * i), 32'd0, st);
    idle(1, 0);
    got = 0;
    first = 0;
    lastc = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rdv[1]) begin
        if (got < 3) seen[got] = rdata[1];
        if (got == 0) first = n;
        lastc = n;
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("b2b_count", got, 3);
    chk("b2b_first", first, 1);
    chk("b2b_span", lastc - first, 2);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_data%0d", i), seen[i], 32'(i + 1));
    v0 = vcnt[1];
    issue(1, 1, 1, 32'd12, 32'h77, st);
    idle(1, 6);
    chk("rw_no_valid", vcnt[1], v0);
    issue(1, 1, 0, 32'd12, 32'd0, st);
    idle(1, 0);
    wait_valid(1, lat, d);
    chk("rw_as_write", d, 32'h77);
`ifdef AVALON_MEM_RESPONDER_STATS_EN
    pulse_reset();
    for (int i = 0; i < 3; i++) issue(0, 1, 0, 32'd0, 32'd0, st);
    for (int i = 0; i < 2; i++) issue(0, 0, 1, 32'd16, 32'(i), st);
    idle(0, 4);
    chk("stats_rd3", rc[0], 32'd3);
    chk("stats_wr2", wc[0], 32'd2);
    pulse_reset();
    @(negedge clk);
    chk("stats_rd_reset", rc[0], 32'd0);
    chk("stats_wr_reset", wc[0], 32'd0);
    @(posedge clk);
    #1;
`endif
    rnd(0, 250);
    rnd(1, 250);
    idle(0, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
